// File: rtl/mmcm_clksel_ctrl.sv
// Reset/clock-select sequencer in front of the MMCM: clk_in_sel only moves while RST is held, and LOCKED is filtered with timeout and retries.
// Outputs are registered (1 cycle after a handshake). Requests are taken only in LOCKED/FAIL; busy states ignore req_valid.
module mmcm_clksel_ctrl #(
  parameter bit INIT_SEL        = 1'b0,
  parameter int RST_PRE_CYCLES  = 8,
  parameter int RST_POST_CYCLES = 8,
  parameter int LOCK_STABLE     = 4,
  parameter int LOCK_TIMEOUT    = 100000,
  parameter int MAX_RETRIES     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic mmcm_rst,
  output logic mmcm_clkinsel,
  input  logic mmcm_locked,
  output logic locked,
  output logic busy,
  output logic err,
  output logic lock_lost,
  output logic cur_sel
);

  localparam int PH_MAX = (RST_PRE_CYCLES > RST_POST_CYCLES) ? RST_PRE_CYCLES : RST_POST_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W   = $clog2(LOCK_STABLE + 1);
  localparam int RT_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [PH_W-1:0] PRE_LAST  = PH_W'(RST_PRE_CYCLES - 1);
  localparam logic [PH_W-1:0] POST_LAST = PH_W'(RST_POST_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_END    = TO_W'(LOCK_TIMEOUT);
  localparam logic [ST_W-1:0] ST_END    = ST_W'(LOCK_STABLE);
  localparam logic [RT_W-1:0] RT_MAX    = RT_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RST_PRE,
    S_SWITCH,
    S_RST_POST,
    S_WAIT_LOCK,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic            pending_q, pending_d;
  logic            sel_q, sel_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [ST_W-1:0] st_q, st_d;
  logic [RT_W-1:0] rt_q, rt_d;
  logic            sync1_q, sync2_q;
  logic            rst_q, ready_q, locked_q, busy_q, err_q, lost_q, lost_d;

  logic            synced;
  logic            hs;
  logic [TO_W-1:0] to_inc;
  logic [ST_W-1:0] st_inc;

  assign synced = sync2_q;
  assign hs     = req_valid && ready_q;
  assign to_inc = to_q + 1'b1;
  assign st_inc = synced ? st_q + 1'b1 : '0;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    ph_d      = '0;
    to_d      = '0;
    st_d      = '0;
    rt_d      = rt_q;
    lost_d    = 1'b0;
    case (state_q)
      S_RST_PRE: begin
        // clkinsel is loaded on the edge into SWITCH so the new select is presented during the SWITCH cycle
        if (ph_q == PRE_LAST) begin
          state_d = S_SWITCH;
          sel_d   = pending_q;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_SWITCH: state_d = S_RST_POST;
      S_RST_POST: begin
        if (ph_q == POST_LAST) state_d = S_WAIT_LOCK;
        else                   ph_d    = ph_q + 1'b1;
      end
      S_WAIT_LOCK: begin
        to_d = to_inc;
        st_d = st_inc;
        if (st_inc == ST_END) begin
          state_d = S_LOCKED;
          rt_d    = '0;
        end else if (to_inc == TO_END) begin
          if (rt_q < RT_MAX) begin
            rt_d    = rt_q + 1'b1;
            state_d = S_RST_PRE;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_LOCKED: begin
        // a request arriving with a lock drop takes priority and suppresses lock_lost
        if (hs && ((req_sel != sel_q) || !synced)) begin
          pending_d = req_sel;
          rt_d      = '0;
          state_d   = S_RST_PRE;
        end else if (!synced) begin
          lost_d  = 1'b1;
          rt_d    = '0;
          state_d = S_RST_PRE;
        end
      end
      S_FAIL: begin
        if (hs) begin
          pending_d = req_sel;
          rt_d      = '0;
          state_d   = S_RST_PRE;
        end
      end
      default: state_d = S_RST_PRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RST_PRE;
      pending_q <= INIT_SEL;
      sel_q     <= INIT_SEL;
      ph_q      <= '0;
      to_q      <= '0;
      st_q      <= '0;
      rt_q      <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      rst_q     <= 1'b1;
      ready_q   <= 1'b0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b1;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      ph_q      <= ph_d;
      to_q      <= to_d;
      st_q      <= st_d;
      rt_q      <= rt_d;
      sync1_q   <= mmcm_locked;
      sync2_q   <= sync1_q;
      rst_q     <= !((state_d == S_WAIT_LOCK) || (state_d == S_LOCKED));
      ready_q   <= (state_d == S_LOCKED) || (state_d == S_FAIL);
      locked_q  <= (state_d == S_LOCKED);
      busy_q    <= !((state_d == S_LOCKED) || (state_d == S_FAIL));
      err_q     <= (state_d == S_FAIL);
      lost_q    <= lost_d;
    end
  end

  assign req_ready     = ready_q;
  assign mmcm_rst      = rst_q;
  assign mmcm_clkinsel = sel_q;
  assign cur_sel       = sel_q;
  assign locked        = locked_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign lock_lost     = lost_q;

endmodule
